ex_mem_pipe: RTL



---
 rtl/ex_mem_pipe.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with branch resolution, PC redirect, front-end flush and EX bubble.
// Optional taken/bubble counters are built when EX_MEM_BRANCH_STATS_EN is defined.
module ex_mem_pipe (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i,
  input  logic [31:0] rt_data_i,
  input  logic [4:0]  write_reg_i,
  input  logic        reg_write_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        mem_to_reg_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_i,
  output logic        valid_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] rt_data_o,
  output logic [4:0]  write_reg_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        mem_to_reg_o,
  output logic        pc_src_o,
  output logic [31:0] branch_target_o,
`ifdef EX_MEM_BRANCH_STATS_EN
  output logic [15:0] taken_cnt_o,
  output logic [15:0] bubble_cnt_o,
`endif
  output logic        flush_o
);

  typedef enum logic [0:0] {StRun, StRedir} state_e;

  state_e state_q, state_d;

  logic        take;
  logic        valid_q, valid_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] rt_data_q, rt_data_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic [31:0] branch_target_q, branch_target_d;

  assign take = valid_i & branch_i & alu_zero_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a branch sitting in the bubble slot cannot chain a redirect
  always_comb begin
    state_d = state_q;
    if (!stall_i) begin
      unique case (state_q)
        StRun:   state_d = take ? StRedir : StRun;
        StRedir: state_d = StRun;
        default: state_d = StRun;
      endcase
    end
  end

  // Output logic
  always_comb begin
    pc_src_o = 1'b0;
    flush_o  = 1'b0;
    if (state_q == StRedir) begin
      pc_src_o = 1'b1;
      flush_o  = 1'b1;
    end
  end

  // Datapath next-state: stall holds, redirect inserts a bubble, otherwise capture
  always_comb begin
    valid_d         = valid_q;
    alu_result_d    = alu_result_q;
    rt_data_d       = rt_data_q;
    write_reg_d     = write_reg_q;
    reg_write_d     = reg_write_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_to_reg_d    = mem_to_reg_q;
    branch_target_d = branch_target_q;
    if (!stall_i) begin
      alu_result_d = alu_result_i;
      rt_data_d    = rt_data_i;
      write_reg_d  = write_reg_i;
      if (state_q == StRedir) begin
        valid_d      = 1'b0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
      end else begin
        valid_d      = valid_i;
        reg_write_d  = reg_write_i & valid_i;
        mem_read_d   = mem_read_i & valid_i;
        mem_write_d  = mem_write_i & valid_i;
        mem_to_reg_d = mem_to_reg_i & valid_i;
        if (take) begin
          branch_target_d = branch_target_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q         <= 1'b0;
      alu_result_q    <= 32'h0;
      rt_data_q       <= 32'h0;
      write_reg_q     <= 5'h0;
      reg_write_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      branch_target_q <= 32'h0;
    end else begin
      valid_q         <= valid_d;
      alu_result_q    <= alu_result_d;
      rt_data_q       <= rt_data_d;
      write_reg_q     <= write_reg_d;
      reg_write_q     <= reg_write_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_to_reg_q    <= mem_to_reg_d;
      branch_target_q <= branch_target_d;
    end
  end

  assign valid_o         = valid_q;
  assign alu_result_o    = alu_result_q;
  assign rt_data_o       = rt_data_q;
  assign write_reg_o     = write_reg_q;
  assign reg_write_o     = reg_write_q;
  assign mem_read_o      = mem_read_q;
  assign mem_write_o     = mem_write_q;
  assign mem_to_reg_o    = mem_to_reg_q;
  assign branch_target_o = branch_target_q;

`ifdef EX_MEM_BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating event counters
  always_comb begin
    taken_cnt_d  = taken_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!stall_i && state_q == StRun && take && taken_cnt_q != 16'hFFFF) begin
      taken_cnt_d = taken_cnt_q + 16'd1;
    end
    if (!stall_i && state_q == StRedir && bubble_cnt_q != 16'hFFFF) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      taken_cnt_q  <= 16'h0;
      bubble_cnt_q <= 16'h0;
    end else begin
      taken_cnt_q  <= taken_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign taken_cnt_o  = taken_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
